// File: rtl/rom_sprite_overlay.sv
// rom_sprite_overlay: overlays a 16x16 ROM sprite on an RGB888 video stream.
// The sprite position and enable are captured on each vsync rising edge.
// The video and sync signals pass through a 3-stage pipeline. The ROM read takes
// the middle stage. Each ROM byte is the alpha of its pixel.
// Macro SPRITE_BLEND_EN: when defined, linear alpha blend per channel. When
// undefined, a threshold composite on alpha[7] with no multipliers.
module rom_sprite_overlay #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned POS_WIDTH  = 12,
    parameter logic [23:0] SPR_COLOR  = 24'hFF0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vid_de,
    input  logic                  vid_hs,
    input  logic                  vid_vs,
    input  logic [23:0]           vid_rgb,
    input  logic [POS_WIDTH-1:0]  pos_x,
    input  logic [POS_WIDTH-1:0]  pos_y,
    input  logic                  spr_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [7:0]            rom_data,
    output logic                  out_de,
    output logic                  out_hs,
    output logic                  out_vs,
    output logic [23:0]           out_rgb
);

    localparam int unsigned HALF_W  = ADDR_WIDTH / 2;
    localparam int unsigned VID_W   = 27;
    localparam logic [0:0]  WAIT_VS = 1'b0;
    localparam logic [0:0]  RUN     = 1'b1;
    localparam logic [POS_WIDTH-1:0] CNT_MAX = '1;

    logic [0:0]            state_q, state_d;
    logic                  vs_prev_q, vs_prev_d;
    logic                  de_prev_q, de_prev_d;
    logic [POS_WIDTH-1:0]  x_q, x_d;
    logic [POS_WIDTH-1:0]  y_q, y_d;
    logic [POS_WIDTH-1:0]  px_q, px_d;
    logic [POS_WIDTH-1:0]  py_q, py_d;
    logic                  en_q, en_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic                  hit1_q, hit1_d;
    logic                  hit2_q, hit2_d;
    logic [VID_W-1:0]      vid1_q, vid1_d;
    logic [VID_W-1:0]      vid2_q, vid2_d;
    logic [VID_W-1:0]      out_q, out_d;

    logic                  vs_rise;
    logic                  de_fall;
    logic [POS_WIDTH:0]    dx;
    logic [POS_WIDTH:0]    dy;
    logic                  hit_c;

`ifdef SPRITE_BLEND_EN
    // One channel of (src*(256-a) + col*a) >> 8, exact at both alpha extremes.
    function automatic logic [7:0] blend_ch(input logic [7:0] src,
                                            input logic [7:0] col,
                                            input logic [7:0] a);
        logic [16:0] acc;
        acc = '0;
        if (a == 8'h00) begin
            blend_ch = src;
        end else if (a == 8'hFF) begin
            blend_ch = col;
        end else begin
            acc = 17'(src) * (17'd256 - 17'(a)) + 17'(col) * 17'(a);
            blend_ch = 8'(acc >> 8);
        end
    endfunction
`endif

    // Mode FSM, frame latch and saturating pixel counters.
    always_comb begin
        vs_rise   = vid_vs & ~vs_prev_q;
        de_fall   = ~vid_de & de_prev_q;
        state_d   = state_q;
        vs_prev_d = vid_vs;
        de_prev_d = vid_de;
        px_d      = px_q;
        py_d      = py_q;
        en_d      = en_q;
        x_d       = x_q;
        y_d       = y_q;

        if (state_q == WAIT_VS && vs_rise) begin
            state_d = RUN;
        end

        if (vs_rise) begin
            px_d = pos_x;
            py_d = pos_y;
            en_d = spr_en;
        end

        if (!vid_de) begin
            x_d = '0;
        end else if (x_q != CNT_MAX) begin
            x_d = x_q + POS_WIDTH'(1);
        end

        if (vs_rise) begin
            y_d = '0;
        end else if (de_fall && y_q != CNT_MAX) begin
            y_d = y_q + POS_WIDTH'(1);
        end
    end

    // Hit test and ROM address. A borrow into the top bit means the pixel is left of or above the sprite.
    always_comb begin
        dx         = {1'b0, x_q} - {1'b0, px_q};
        dy         = {1'b0, y_q} - {1'b0, py_q};
        hit_c      = (state_q == RUN) && en_q && vid_de &&
                     (dx[POS_WIDTH:HALF_W] == '0) && (dy[POS_WIDTH:HALF_W] == '0);
        rom_addr_d = hit_c ? {dy[HALF_W-1:0], dx[HALF_W-1:0]} : '0;
        hit1_d     = hit_c;
        hit2_d     = hit1_q;
        vid1_d     = {vid_de, vid_hs, vid_vs, vid_rgb};
        vid2_d     = vid1_q;
    end

    // Composite stage: uses rom_data returned for the pixel now in stage 2.
    always_comb begin
        out_d = vid2_q;
        if (hit2_q) begin
`ifdef SPRITE_BLEND_EN
            for (int c = 0; c < 3; c++) begin
                out_d[c*8 +: 8] = blend_ch(vid2_q[c*8 +: 8], SPR_COLOR[c*8 +: 8], rom_data);
            end
`else
            if (rom_data >= 8'h80) begin
                out_d[23:0] = SPR_COLOR;
            end
`endif
        end
    end

    // State, counters and pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_VS;
            vs_prev_q  <= 1'b0;
            de_prev_q  <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            px_q       <= '0;
            py_q       <= '0;
            en_q       <= 1'b0;
            rom_addr_q <= '0;
            hit1_q     <= 1'b0;
            hit2_q     <= 1'b0;
            vid1_q     <= '0;
            vid2_q     <= '0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            vs_prev_q  <= vs_prev_d;
            de_prev_q  <= de_prev_d;
            x_q        <= x_d;
            y_q        <= y_d;
            px_q       <= px_d;
            py_q       <= py_d;
            en_q       <= en_d;
            rom_addr_q <= rom_addr_d;
            hit1_q     <= hit1_d;
            hit2_q     <= hit2_d;
            vid1_q     <= vid1_d;
            vid2_q     <= vid2_d;
            out_q      <= out_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign out_de   = out_q[26];
    assign out_hs   = out_q[25];
    assign out_vs   = out_q[24];
    assign out_rgb  = out_q[23:0];

endmodule

// File: tb/tb_rom_sprite_overlay.sv
// tb_rom_sprite_overlay: directed frames with random pixels, random ROM contents and random positions.
// Each cycle the outputs are compared with a coordinate-based reference model.
module tb_rom_sprite_overlay;

    localparam int W  = 40;
    localparam int H  = 24;
    localparam int HB = 8;
    localparam logic [23:0] COL = 24'hFF0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        vid_de, vid_hs, vid_vs;
    logic [23:0] vid_rgb;
    logic [11:0] pos_x, pos_y;
    logic        spr_en;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        out_de, out_hs, out_vs;
    logic [23:0] out_rgb;

    logic [7:0]  rom_mem [256];

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit          m_run, m_en, m_vs_prev;
    int          m_px, m_py;
    logic [26:0] p1, p2, exp_out;
    bit          h1, h2, exp_hit;
    logic [7:0]  exp_addr;
    bit          chk_const;
    logic [23:0] const_rgb;
    int          spr_count;

    always #5 clk = ~clk;

    // Behavioural 256x8 ROM with a 1-cycle registered read
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    rom_sprite_overlay #(.ADDR_WIDTH(8), .POS_WIDTH(12), .SPR_COLOR(COL)) dut (
        .clk(clk), .rst(rst), .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
        .vid_rgb(vid_rgb), .pos_x(pos_x), .pos_y(pos_y), .spr_en(spr_en),
        .rom_addr(rom_addr), .rom_data(rom_data), .out_de(out_de), .out_hs(out_hs),
        .out_vs(out_vs), .out_rgb(out_rgb)
    );

    function automatic logic [23:0] model_pix(input logic [23:0] src, input int a);
        logic [23:0] r;
        logic [23:0] col;
        int s, c, v;
        col = COL;
        r   = '0;
        for (int k = 0; k < 3; k++) begin
            s = int'(src[k*8 +: 8]);
            c = int'(col[k*8 +: 8]);
`ifdef SPRITE_BLEND_EN
            if (a == 0)        v = s;
            else if (a == 255) v = c;
            else               v = (s * (256 - a) + c * a) / 256;
`else
            v = (a >= 128) ? c : s;
`endif
            r[k*8 +: 8] = 8'(v);
        end
        return r;
    endfunction

    function automatic logic [23:0] src_pix(input int mode);
        logic [23:0] r;
        if (mode == 1) return 24'h000000;
        r = 24'($urandom);
        if (mode == 2) r[23:16] = 8'h00;
        return r;
    endfunction

    // Drive one clock of inputs; col/row are the pixel's position in the frame.
    task automatic step(input bit r, input bit de, input bit hs, input bit vs,
                        input logic [23:0] rgb, input int col, input int row);
        int          dx, dy;
        bit          hit;
        logic [7:0]  addr;
        logic [26:0] ent;
        rst = r; vid_de = de; vid_hs = hs; vid_vs = vs; vid_rgb = rgb;
        dx   = col - m_px;
        dy   = row - m_py;
        hit  = m_run && m_en && de && dx >= 0 && dx < 16 && dy >= 0 && dy < 16;
        addr = hit ? 8'(dy * 16 + dx) : 8'h00;
        ent  = {de, hs, vs, hit ? model_pix(rgb, int'(rom_mem[addr])) : rgb};
        @(posedge clk);
        if (r) begin
            p1 = '0; p2 = '0; h1 = 0; h2 = 0; exp_out = '0; exp_hit = 0; exp_addr = '0;
            m_run = 0; m_en = 0; m_px = 0; m_py = 0; m_vs_prev = 0;
        end else begin
            exp_out = p2; exp_hit = h2;
            p2 = p1; h2 = h1;
            p1 = ent; h1 = hit;
            exp_addr = addr;
            if (vs && !m_vs_prev) begin
                m_run = 1; m_px = int'(pos_x); m_py = int'(pos_y); m_en = spr_en;
            end
            m_vs_prev = vs;
        end
        #1;
        tests++;
        assert ({out_de, out_hs, out_vs, out_rgb} === exp_out) else begin
            fails++;
            $error("FAIL video observed=%h expected=%h", {out_de, out_hs, out_vs, out_rgb}, exp_out);
        end
        tests++;
        assert (rom_addr === exp_addr) else begin
            fails++;
            $error("FAIL rom_addr observed=%h expected=%h", rom_addr, exp_addr);
        end
        if (chk_const && exp_hit) begin
            tests++;
            assert (out_rgb === const_rgb) else begin
                fails++;
                $error("FAIL alpha_const observed=%h expected=%h", out_rgb, const_rgb);
            end
        end
        if (out_de === 1'b1 && out_rgb === COL) spr_count++;
    endtask

    // One frame: vsync, W x H active area, optional mid-frame pos_x change and reset.
    task automatic frame(input int px, input int py, input bit en, input int src_mode,
                         input int chg_row, input int new_px, input int rst_row);
        pos_x = 12'(px); pos_y = 12'(py); spr_en = en;
        step(0, 0, 0, 1, 24'h0, 0, 0);
        step(0, 0, 0, 1, 24'h0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 24'h0, 0, 0);
        for (int r = 0; r < H; r++) begin
            if (r == chg_row) pos_x = 12'(new_px);
            for (int h = 0; h < HB; h++) step(0, 0, (h < 3), 0, 24'h0, 0, r);
            for (int c = 0; c < W; c++)
                step((r == rst_row && c >= 10 && c < 13), 1, 0, 0, src_pix(src_mode), c, r);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 24'h0, 0, H);
    endtask

    task automatic fill_rom(input int mode, input logic [7:0] val);
        for (int i = 0; i < 256; i++) rom_mem[i] = (mode == 0) ? val : 8'($urandom);
    endtask

    initial begin
        chk_const = 0; const_rgb = '0; spr_count = 0;
        m_run = 0; m_en = 0; m_vs_prev = 0; m_px = 0; m_py = 0;
        p1 = '0; p2 = '0; h1 = 0; h2 = 0; exp_out = '0; exp_hit = 0; exp_addr = '0;
        pos_x = '0; pos_y = '0; spr_en = 0;
        fill_rom(1, 8'h00);

        // Reset: all outputs zero
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 24'h0, 0, 0);

        // Pass-through before any vsync, with incrementing pixels
        spr_en = 1; pos_x = 12'd0; pos_y = 12'd0;
        for (int i = 0; i < 30; i++) step(0, 1, 0, 0, 24'(i + 1), i, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 24'h0, 0, 0);

        // Opaque sprite fully inside the frame: exactly 256 sprite pixels
        fill_rom(0, 8'hFF);
        spr_count = 0;
        frame(10, 5, 1, 2, -1, 0, -1);
        tests++;
        assert (spr_count === 256) else begin
            fails++; $error("FAIL opaque_count observed=%0d expected=%0d", spr_count, 256);
        end

        // Alpha 0x80 over black
        fill_rom(0, 8'h80);
`ifdef SPRITE_BLEND_EN
        const_rgb = 24'h7F0000;
`else
        const_rgb = 24'hFF0000;
`endif
        chk_const = 1;
        frame(3, 2, 1, 1, -1, 0, -1);
        chk_const = 0;

        // Alpha 0x7F: never the full sprite colour over a red-free source
        fill_rom(0, 8'h7F);
        spr_count = 0;
        frame(7, 4, 1, 2, -1, 0, -1);
        tests++;
        assert (spr_count === 0) else begin
            fails++; $error("FAIL alpha7f_count observed=%0d expected=%0d", spr_count, 0);
        end

        // Clipping at the right and bottom edges: 10 x 5 pixels
        fill_rom(0, 8'hFF);
        spr_count = 0;
        frame(W - 10, H - 5, 1, 2, -1, 0, -1);
        tests++;
        assert (spr_count === 50) else begin
            fails++; $error("FAIL clip_count observed=%0d expected=%0d", spr_count, 50);
        end

        // Overlay disabled
        spr_count = 0;
        frame(10, 5, 0, 2, -1, 0, -1);
        tests++;
        assert (spr_count === 0) else begin
            fails++; $error("FAIL disabled_count observed=%0d expected=%0d", spr_count, 0);
        end

        // Random ROM, random positions, random pixels
        fill_rom(1, 8'h00);
        for (int f = 0; f < 3; f++)
            frame($urandom_range(0, W + 2), $urandom_range(0, H + 2), ($urandom_range(0, 3) != 0), 0, -1, 0, -1);

        // pos_x change mid-frame is ignored; the next frame uses it
        frame(5, 3, 1, 0, 6, 22, -1);
        frame(22, 3, 1, 0, -1, 0, -1);

        // Reset during a sprite row, then recovery on the next frame
        frame(5, 3, 1, 0, -1, 0, 6);
        frame(5, 3, 1, 0, -1, 0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rom_sprite_overlay.md
# rom_sprite_overlay

Reads the 16×16 sprite ROM (`rom_square`, 256×8, 1-cycle registered read) as its address initiator and overlays the sprite onto a live RGB888 video stream. It sits in the HDMI output path between the timing/pixel source and the HDMI encoder. The sprite position is set per frame. Each ROM byte is the pixel's alpha, and the block blends a fixed sprite colour over the source pixel.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: ROM address width; sprite side = 2**(ADDR_WIDTH/2) = 16; must be even.
- `POS_WIDTH`, 12: width of pixel counters and position inputs.
- `SPR_COLOR`, 24'hFF0000: sprite RGB colour.

Ports:
- `clk`, in, 1: pixel clock; the only clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `vid_de`, in, 1: active-video enable.
- `vid_hs`, in, 1: hsync, passed through.
- `vid_vs`, in, 1: vsync, active-high.
- `vid_rgb`, in, 24: source pixel {R,G,B}.
- `pos_x`, in, POS_WIDTH: sprite left column.
- `pos_y`, in, POS_WIDTH: sprite top row.
- `spr_en`, in, 1: overlay enable.
- `rom_addr`, out, ADDR_WIDTH: to ROM `addr`.
- `rom_data`, in, 8: from ROM `rd_data`; valid one clock after `rom_addr` is sampled.
- `out_de`, out, 1: delayed `vid_de`.
- `out_hs`, out, 1: delayed `vid_hs`.
- `out_vs`, out, 1: delayed `vid_vs`.
- `out_rgb`, out, 24: composited pixel.

## Operation
- **FSM states:**
  - WAIT_VS, entered on reset. Pure pass-through, no hits.
  - RUN, entered on the first `vid_vs` rising edge.
  - Only `rst` leaves RUN.
- **Frame latch:** on each `vid_vs` rising edge, capture `pos_x`, `pos_y` and `spr_en`. Mid-frame input changes are ignored.
- **x counter:** increments on every clock with `vid_de`=1. Cleared while `vid_de`=0.
- **y counter:** increments on each `vid_de` falling edge. Cleared on the `vid_vs` rising edge.
- **Hit:** RUN && latched `spr_en` && x−px < 16 && y−py < 16.
  - Both subtractions are done at POS_WIDTH+1 bits, so a negative result means no hit.
  - A sprite overhanging the right or bottom edge is clipped naturally.
- **Address:** `rom_addr` = {(y−py)[3:0], (x−px)[3:0]} (row-major) on a hit, else 0.
- **Blend:** alpha a = `rom_data`, applied per 8-bit channel.
  - a=0 → source pixel.
  - a=255 → `SPR_COLOR` exactly.
  - Otherwise out = (src·(256−a) + col·a) >> 8, with a 17-bit intermediate, truncated.
  - No hit → source pixel unchanged.
- **Sync path:** `vid_de`, `vid_hs` and `vid_vs` are delayed by the same number of stages as `vid_rgb`; they are never modified.

## Timing
- 3-stage pipeline, input to output latency exactly 3 clocks, for all video and sync signals.
  - Edge T: register `rom_addr`, hit flag and video stage 1.
  - Edge T+1: ROM registers its data; video stage 2 and hit stage 2 are registered.
  - Edge T+2: blend and register `out_*`.
- **Reset values:** `rom_addr`, `out_de`, `out_hs`, `out_vs` and `out_rgb` are all 0. Counters and latches are 0. State is WAIT_VS.
- **Reset mid-frame:** outputs are 0 while `rst`=1. After release, the first 3 output clocks are flushed zeros. After that, video passes through unmodified until the next `vid_vs` rise.
- **Simultaneous `vid_vs` rise and `vid_de`=1:** the latch and y clear take effect, and the x counter still counts.
- **Counter wrap:** counters saturate at all-ones and never wrap.

## Configuration
- **`SPRITE_BLEND_EN` defined:** linear alpha blend as above.
- **Not defined:** threshold compositing with no multipliers.
  - `rom_data`[7]=1 → `SPR_COLOR`.
  - `rom_data`[7]=0 → source.
  - Latency is unchanged (3 clocks).

## Test plan
- **Pass-through before vsync:** reset, then drive `vid_de`=1 with incrementing `vid_rgb` before any `vid_vs` → `out_rgb` equals input delayed 3 clocks, `rom_addr` stays 0.
- **Full hit, opaque:** ROM all 8'hFF, pos (100,50), `spr_en`=1, 1280×720 frame → `SPR_COLOR` at exactly x 100..115, y 50..65. `rom_addr` sequence 0x00..0x0F on row 50 and 0xF0..0xFF on row 65. Everything else is source.
- **Alpha blend with `SPRITE_BLEND_EN`:** `rom_data`=8'h80, src 24'h000000, colour FF0000 → 24'h7F0000. Without the macro → 24'hFF0000. With `rom_data`=8'h7F and no macro → source.
- **Clipping:** pos (1270,715) on 1280×720 → only 10×5 sprite pixels are replaced; no wrap to x=0 or y=0.
- **Mid-frame position change:** change `pos_x` during the active frame → output is unchanged until the next `vid_vs` rise, then the sprite moves.
- **Reset mid-line:** assert `rst` during a sprite row → all outputs 0 during reset and for 3 clocks after release, then pass-through with no overlay until the next vsync.
